lea_round_controller: RTL and testbench

LEA_ROUND_CONTROLLER -- requirements
Module: lea_round_controller

---
 rtl/lea_round_controller.sv | 104 ++++++++++
 tb/tb_lea_round_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lea_round_controller.sv
// Round sequencing controller for a LEA block-cipher datapath: loads a plaintext block,
// steps NUM_ROUNDS keyed round updates, then holds the ciphertext until it is consumed.
module lea_round_controller #(
    parameter int unsigned NUM_ROUNDS = 24,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             key_valid,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             msg_ce,
    output logic             msg_sel,
    output logic             key_req,
    output logic [4:0]       round_idx,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    localparam logic [4:0] LastRound = 5'(NUM_ROUNDS - 1);

    state_e           state_q;
    logic [4:0]       round_q;
    logic [CNT_W-1:0] cnt_q;
    logic             advance;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        key_req   = 1'b0;
        msg_sel   = 1'b0;
        advance   = 1'b0;
        case (state_q)
            StIdle:  in_ready = 1'b1;
            StRound: begin
                busy    = 1'b1;
                key_req = 1'b1;
                msg_sel = 1'b1;
                advance = key_valid & ~abort;
            end
            StDone: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
        // Reset must never let the message register capture or signal acceptance.
        if (rst) begin
            in_ready = 1'b0;
            advance  = 1'b0;
        end
        msg_ce = (in_ready & in_valid) | advance;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q <= StRound;
                        round_q <= '0;
                    end
                end
                StRound: begin
                    if (abort) begin
                        state_q <= StIdle;
                        round_q <= '0;
                    end else if (key_valid) begin
                        if (round_q == LastRound) begin
                            state_q <= StDone;
                        end else begin
                            round_q <= round_q + 5'd1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        round_q <= '0;
                        state_q <= in_valid ? StRound : StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    round_q <= '0;
                end
            endcase
        end
    end

    assign round_idx = round_q;
    assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_lea_round_controller.sv
// Randomized and directed checks of lea_round_controller against a transaction-level model.
module tb_lea_round_controller;

    localparam int unsigned NR = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, key_valid, abort, out_ready;
    logic in_ready, out_valid, msg_ce, msg_sel, key_req, busy;
    logic [4:0] round_idx;
    logic [15:0] blk_cnt;
    logic in_ready2, out_valid2, msg_ce2, msg_sel2, key_req2, busy2;
    logic [4:0] round_idx2;
    logic [1:0] blk_cnt2;

    int vectors = 0;
    int miscompares = 0;

    // Model: a block is either absent, mid-computation (m_done rounds applied) or finished.
    bit m_has;
    int m_done;
    int m_deliv;
    bit m_idx_zero;

    logic o_ce, o_sel, o_ov, o_ir, o_busy, o_kreq;
    logic [4:0] o_idx;
    logic [15:0] o_blk;
    logic [1:0] o_blk2;
    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    lea_round_controller #(.NUM_ROUNDS(NR), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .key_valid(key_valid), .abort(abort), .out_ready(out_ready),
        .out_valid(out_valid), .msg_ce(msg_ce), .msg_sel(msg_sel), .key_req(key_req),
        .round_idx(round_idx), .busy(busy), .blk_cnt(blk_cnt)
    );

    lea_round_controller #(.NUM_ROUNDS(NR), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .key_valid(key_valid), .abort(abort), .out_ready(out_ready),
        .out_valid(out_valid2), .msg_ce(msg_ce2), .msg_sel(msg_sel2), .key_req(key_req2),
        .round_idx(round_idx2), .busy(busy2), .blk_cnt(blk_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, $time / 10);
        end
    endtask

    task automatic drive_cycle(input logic r, input logic iv, input logic kv, input logic ab,
                               input logic ordy);
        bit comp, rdy, e_ir, e_ce;
        @(negedge clk);
        rst = r; in_valid = iv; key_valid = kv; abort = ab; out_ready = ordy;
        #1;
        comp = m_has && (m_done < int'(NR));
        rdy  = m_has && (m_done == int'(NR));
        e_ir = !r && (!m_has || (rdy && ordy));
        e_ce = !r && ((e_ir && iv) || (comp && kv && !ab));
        check("in_ready", in_ready, e_ir);
        check("out_valid", out_valid, rdy);
        check("busy", busy, comp);
        check("key_req", key_req, comp);
        check("msg_ce", msg_ce, e_ce);
        if (e_ce) check("msg_sel", msg_sel, comp);
        if (comp) check("round_idx", round_idx, m_done);
        else if (rdy) check("round_idx", round_idx, NR - 1);
        else if (m_idx_zero) check("round_idx", round_idx, 0);
        check("blk_cnt", blk_cnt, m_deliv % 65536);
        check("blk_cnt_w2", blk_cnt2, m_deliv % 4);
        check("out_valid_w2", out_valid2, rdy);
        check("msg_ce_w2", msg_ce2, e_ce);
        o_ce = msg_ce; o_sel = msg_sel; o_ov = out_valid; o_ir = in_ready;
        o_busy = busy; o_kreq = key_req; o_idx = round_idx; o_blk = blk_cnt; o_blk2 = blk_cnt2;
        @(posedge clk);
        if (r) begin
            m_has = 0; m_done = 0; m_deliv = 0; m_idx_zero = 1;
        end else if (comp) begin
            if (ab) begin
                m_has = 0; m_idx_zero = 1;
            end else if (kv) begin
                m_done++;
            end
        end else if (rdy) begin
            if (ordy) begin
                m_deliv++;
                if (iv) m_done = 0;
                else begin
                    m_has = 0; m_idx_zero = 0;
                end
            end
        end else if (iv) begin
            m_has = 1; m_done = 0;
        end
    endtask

    // Accepts one block from IDLE and runs it until out_valid; stalls keys at a given round.
    task automatic run_block(input int stall_at, input int stall_len, input logic ordy,
                             output int lat, output int rounds, output int loads,
                             output int idx_ok);
        logic kv;
        lat = -1; rounds = 0; loads = 0; idx_ok = 1;
        drive_cycle(0, 1, 1, 0, 1);
        if (o_ce && !o_sel) loads++;
        for (int i = 1; i <= int'(NR) + 40; i++) begin
            kv = !((i - 1) >= stall_at && (i - 1) < stall_at + stall_len);
            drive_cycle(0, 0, kv, 0, ordy);
            if (o_ce && o_sel) begin
                if (int'(o_idx) != rounds) idx_ok = 0;
                rounds++;
            end
            if (o_ce && !o_sel) loads++;
            if (o_ov) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain();
        int seen = 0;
        for (int i = 0; i < int'(NR) + 40; i++) begin
            drive_cycle(0, 0, 1, 0, 1);
            if (o_ov) begin
                seen = 1;
                break;
            end
        end
        check("drain_done", seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, rounds, loads, idx_ok;
        rst = 1; in_valid = 0; key_valid = 0; abort = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        m_has = 0; m_done = 0; m_deliv = 0; m_idx_zero = 1;

        // Reset state, then a single block with keys always present.
        drive_cycle(1, 1, 1, 1, 1);
        check("rst_msg_ce", o_ce, 0);
        check("rst_in_ready", o_ir, 0);
        drive_cycle(0, 0, 0, 0, 0);
        check("idle_idx", o_idx, 0);
        check("idle_ov", o_ov, 0);
        run_block(99, 0, 1, lat, rounds, loads, idx_ok);
        check("s1_latency", lat, 25);
        check("s1_rounds", rounds, 24);
        check("s1_loads", loads, 1);
        check("s1_idx_seq", idx_ok, 1);
        drive_cycle(0, 0, 0, 0, 0);
        check("s1_blk", o_blk, 1);

        // Three-cycle key stall at round 5.
        run_block(5, 3, 1, lat, rounds, loads, idx_ok);
        check("s2_latency", lat, 28);
        check("s2_rounds", rounds, 24);
        check("s2_idx_seq", idx_ok, 1);
        drive_cycle(0, 0, 0, 0, 0);

        // Consumer backpressure in DONE, then a back-to-back load.
        run_block(99, 0, 0, lat, rounds, loads, idx_ok);
        check("s3_latency", lat, 25);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(0, 0, 0, 0, 0);
            check("s3_hold_ov", o_ov, 1);
            check("s3_hold_ir", o_ir, 0);
            check("s3_hold_blk", o_blk, 2);
        end
        drive_cycle(0, 1, 1, 0, 1);
        check("s3_b2b_ce", o_ce, 1);
        check("s3_b2b_sel", o_sel, 0);
        check("s3_b2b_ir", o_ir, 1);
        drive_cycle(0, 0, 1, 0, 1);
        check("s3_b2b_busy", o_busy, 1);
        check("s3_b2b_idx", o_idx, 0);
        check("s3_b2b_blk", o_blk, 3);
        drain();
        drive_cycle(0, 0, 0, 0, 0);

        // Abort at round 10, then a normal block.
        drive_cycle(0, 1, 1, 0, 1);
        repeat (10) drive_cycle(0, 0, 1, 0, 1);
        drive_cycle(0, 0, 1, 1, 1);
        check("s4_abort_idx", o_idx, 10);
        check("s4_abort_ce", o_ce, 0);
        drive_cycle(0, 0, 0, 0, 1);
        check("s4_busy", o_busy, 0);
        check("s4_ir", o_ir, 1);
        check("s4_idx", o_idx, 0);
        check("s4_ov", o_ov, 0);
        check("s4_blk", o_blk, 4);
        run_block(99, 0, 1, lat, rounds, loads, idx_ok);
        check("s4_latency", lat, 25);
        drive_cycle(0, 0, 0, 0, 0);
        check("s4_blk_after", o_blk, 5);

        // Reset mid-ROUND at round 12.
        drive_cycle(0, 1, 1, 0, 1);
        repeat (12) drive_cycle(0, 0, 1, 0, 1);
        drive_cycle(1, 1, 1, 1, 1);
        check("s5_rst_idx_before", o_idx, 12);
        check("s5_rst_ce", o_ce, 0);
        check("s5_rst_ir", o_ir, 0);
        drive_cycle(0, 0, 0, 0, 0);
        check("s5_idx", o_idx, 0);
        check("s5_blk", o_blk, 0);
        check("s5_busy", o_busy, 0);
        check("s5_kreq", o_kreq, 0);
        check("s5_ov", o_ov, 0);

        // Narrow counter wraps.
        for (int k = 0; k < 5; k++) begin
            run_block(99, 0, 1, lat, rounds, loads, idx_ok);
            drive_cycle(0, 0, 0, 0, 0);
            check("s6_wrap", o_blk2, wrap_exp[k]);
        end

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            drive_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 4) != 0, $urandom_range(0, 59) == 0,
                        $urandom_range(0, 4) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
